// File: rtl/uart_debug_pkg.sv
// ---------------------------------------------------------------------------
// uart_debug_pkg : types and helpers shared by the UART debug tx/rx sides.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package uart_debug_pkg;

  localparam int FRAME_W = 9;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_t;

  function automatic int clks_per_bit(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

endpackage

`default_nettype wire

// File: rtl/uart_debug_fifo.sv
// ---------------------------------------------------------------------------
// uart_debug_fifo : synchronous frame FIFO, power-of-two depth.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module uart_debug_fifo #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           wdata,
  input  logic                       pop,
  output logic [WIDTH-1:0]           rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage carries no reset; only the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

`default_nettype wire

// File: rtl/uart_debug_tx.sv
// ---------------------------------------------------------------------------
// uart_debug_tx : buffers 9-bit debug frames and serialises them as
// start, 8 data bits LSB first, parity bit, stop.  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module uart_debug_tx
  import uart_debug_pkg::*;
#(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BAUD       = 115200,
  parameter int FIFO_DEPTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [FRAME_W-1:0] frame,
  input  logic               frame_valid,
  output logic               frame_ready,
  output logic               tx,
  output logic               busy,
  output logic               overflow
);

  localparam int CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD);
  localparam int CNT_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int FCNT_W       = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  tx_state_t          state;
  logic [CNT_W-1:0]   baud_cnt;
  logic [2:0]         bit_idx;
  logic [7:0]         shift;
  logic               parity;

  logic               full;
  logic               empty;
  logic [FCNT_W-1:0]  count;
  logic [FRAME_W-1:0] head;
  logic               push;
  logic               pop;
  logic               bit_end;

  assign frame_ready = !full;
  assign push        = frame_valid && !full;
  assign bit_end     = (baud_cnt == BIT_LAST);
  // The head leaves the FIFO on the same edge it is loaded into the shifter.
  assign pop         = !empty && ((state == IDLE) || (state == STOP && bit_end));
  assign busy        = (state != IDLE) || (count != '0);

  uart_debug_fifo #(
    .WIDTH (FRAME_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata (frame),
    .pop   (pop),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shift    <= '0;
      parity   <= 1'b0;
      tx       <= 1'b1;
      overflow <= 1'b0;
    end else begin
      overflow <= frame_valid && full;
      case (state)
        IDLE: begin
          baud_cnt <= '0;
          if (!empty) begin
            shift  <= head[7:0];
            parity <= head[8];
            tx     <= 1'b0;
            state  <= START;
          end
        end
        START: begin
          if (bit_end) begin
            baud_cnt <= '0;
            bit_idx  <= '0;
            tx       <= shift[0];
            state    <= DATA;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        DATA: begin
          if (bit_end) begin
            baud_cnt <= '0;
            shift    <= shift >> 1;
            if (bit_idx == 3'd7) begin
              tx    <= parity;
              state <= PARITY;
            end else begin
              tx      <= shift[1];
              bit_idx <= bit_idx + 1'b1;
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        PARITY: begin
          if (bit_end) begin
            baud_cnt <= '0;
            tx       <= 1'b1;
            state    <= STOP;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        STOP: begin
          if (bit_end) begin
            baud_cnt <= '0;
            if (!empty) begin
              shift  <= head[7:0];
              parity <= head[8];
              tx     <= 1'b0;
              state  <= START;
            end else begin
              state <= IDLE;
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        default: begin
          baud_cnt <= '0;
          tx       <= 1'b1;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_uart_debug_tx.sv
// ---------------------------------------------------------------------------
// tb_uart_debug_tx : frame-level line model plus directed vectors.  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_uart_debug_tx;

  localparam int DEPTH = 4;
  localparam int CPB   = 10;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [8:0] frame = '0;
  logic       frame_valid = 1'b0;
  logic       frame_ready;
  logic       tx;
  logic       busy;
  logic       overflow;

  int vectors = 0;
  int errs    = 0;
  int ovf_cnt = 0;
  int low_cnt = 0;

  uart_debug_tx #(
    .CLK_FREQ   (1000),
    .BAUD       (100),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .frame       (frame),
    .frame_valid (frame_valid),
    .frame_ready (frame_ready),
    .tx          (tx),
    .busy        (busy),
    .overflow    (overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Line model: queue of accepted frames, and a per-clock list of line levels
  // for the frame currently being sent.
  logic [8:0] mq[$];
  logic       lq[$];
  logic       in_frame = 1'b0;
  logic       e_tx = 1'b1, e_busy = 1'b0, e_ready = 1'b1, e_ovf = 1'b0;
  bit         room;
  logic [8:0] cur;
  logic       lvl;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      mq.delete();
      lq.delete();
      in_frame = 1'b0;
      e_tx = 1'b1; e_busy = 1'b0; e_ready = 1'b1; e_ovf = 1'b0;
    end else begin
      room  = mq.size() < DEPTH;
      e_ovf = frame_valid && !room;
      if (lq.size() == 0 && mq.size() > 0) begin
        cur = mq.pop_front();
        for (int b = 0; b < 11; b++) begin
          if (b == 0)      lvl = 1'b0;
          else if (b < 9)  lvl = cur[b-1];
          else if (b == 9) lvl = cur[8];
          else             lvl = 1'b1;
          repeat (CPB) lq.push_back(lvl);
        end
      end
      if (lq.size() > 0) begin
        e_tx = lq.pop_front();
        in_frame = 1'b1;
      end else begin
        e_tx = 1'b1;
        in_frame = 1'b0;
      end
      if (frame_valid && room) mq.push_back(frame);
      e_ready = mq.size() < DEPTH;
      e_busy  = in_frame || (mq.size() > 0);
    end
  end

  always @(negedge clk) begin
    check("tx", {31'b0, tx}, {31'b0, e_tx});
    check("busy", {31'b0, busy}, {31'b0, e_busy});
    check("frame_ready", {31'b0, frame_ready}, {31'b0, e_ready});
    check("overflow", {31'b0, overflow}, {31'b0, e_ovf});
    if (overflow) ovf_cnt++;
    if (!tx) low_cnt++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Samples each of the 11 bit times mid-bit; the frame's first start-bit
  // edge lies d edges after the current time.
  task automatic sample_frame(input int d, input logic [10:0] exp_bits);
    repeat (d + 5) step();
    for (int i = 0; i < 11; i++) begin
      if (i > 0) repeat (CPB) step();
      check($sformatf("bit%0d", i), {31'b0, tx}, {31'b0, exp_bits[i]});
    end
  endtask

  logic [8:0] t4 [6] = '{9'h011, 9'h122, 9'h033, 9'h144, 9'h055, 9'h166};

  initial begin
    repeat (3) step();
    check("rst_tx", {31'b0, tx}, 32'd1);
    check("rst_ready", {31'b0, frame_ready}, 32'd1);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_ovf", {31'b0, overflow}, 32'd0);
    rst = 1'b1;
    step();

    // Single frame 0x0AA
    frame = 9'h0AA; frame_valid = 1'b1;
    step();
    frame_valid = 1'b0; frame = 'x;
    sample_frame(1, 11'b1_0_10101010_0);
    repeat (4) step();
    check("busy_before_end", {31'b0, busy}, 32'd1);
    step();
    check("busy_after_110", {31'b0, busy}, 32'd0);

    // Back-to-back frames
    repeat (5) step();
    frame = 9'h0AA; frame_valid = 1'b1;
    step();
    frame = 9'h1B3;
    step();
    frame_valid = 1'b0; frame = 'x;
    sample_frame(0, 11'b1_0_10101010_0);
    sample_frame(5, 11'b1_1_10110011_0);
    repeat (120) step();
    check("b2b_idle", {31'b0, busy}, 32'd0);

    // Six consecutive writes, one rejected
    ovf_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      frame = t4[i]; frame_valid = 1'b1;
      step();
      if (i == 4) check("full_ready", {31'b0, frame_ready}, 32'd0);
    end
    frame_valid = 1'b0; frame = 'x;
    repeat (5 * 110 + 20) step();
    check("ovf_pulses", ovf_cnt, 32'd1);
    check("burst_idle", {31'b0, busy}, 32'd0);

    // Reset mid-DATA with two frames queued
    frame = 9'h055; frame_valid = 1'b1; step();
    frame = 9'h1C3; step();
    frame = 9'h0F0; step();
    frame_valid = 1'b0; frame = 'x;
    repeat (40) step();
    rst = 1'b0;
    #1;
    check("mid_rst_tx", {31'b0, tx}, 32'd1);
    check("mid_rst_busy", {31'b0, busy}, 32'd0);
    check("mid_rst_ready", {31'b0, frame_ready}, 32'd1);
    repeat (3) step();
    rst = 1'b1;
    low_cnt = 0;
    repeat (300) step();
    check("no_tx_after_rst", low_cnt, 32'd0);
    check("idle_after_rst", {31'b0, busy}, 32'd0);

    // Write while full coinciding with the STOP-end pop
    frame = 9'h0C1; frame_valid = 1'b1; step();
    frame = 9'h1C2; step();
    frame = 9'h0C3; step();
    frame = 9'h1C4; step();
    frame = 9'h0C5; step();
    frame_valid = 1'b0; frame = 'x;
    repeat (106) step();
    check("pre_pop_ready", {31'b0, frame_ready}, 32'd0);
    frame = 9'h1C6; frame_valid = 1'b1;
    step();
    check("pop_ovf", {31'b0, overflow}, 32'd1);
    check("pop_ready", {31'b0, frame_ready}, 32'd1);
    frame = 9'h0C7;
    step();
    frame_valid = 1'b0; frame = 'x;
    check("refill_ready", {31'b0, frame_ready}, 32'd0);
    check("refill_ovf", {31'b0, overflow}, 32'd0);
    repeat (5 * 110 + 20) step();
    check("final_idle", {31'b0, busy}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule

`default_nettype wire
